// File: rtl/memory_stage.sv
// Memory stage: direct-mapped write-through cache with no write-allocate, in front of a fixed-latency backing memory.
// Optional load hit/miss counters are built when MEMORY_STAGE_PERF_CNT_EN is defined.

module memory_stage_mem #(
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned AW        = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-3:0] rline,
    output logic [127:0]  rdata
);

    logic [31:0] data_mem [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[waddr] <= wdata;
        end
    end

    // The whole aligned line is presented so a fill completes in one edge.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdata[32*k +: 32] = data_mem[{rline, 2'(k)}];
        end
    end

endmodule

module memory_stage #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned NUM_LINES   = 4,
    parameter int unsigned MEM_WORDS   = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  rd_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic        is_write_in,
    output logic [31:0] wb_data_out,
    output logic        stall_req,
    output logic [4:0]  rd_out
);

    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = 28 - IDX_W;
    localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_LINES-1:0] line_valid;
    logic [TAG_W-1:0]     line_tag  [NUM_LINES];
    logic [31:0]          line_data [NUM_LINES][4];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             last;
    logic             mem_we;
    logic [127:0]     mem_line;
    logic             unused_write;

    assign idx          = alu_result_in[IDX_W+3:4];
    assign off          = alu_result_in[3:2];
    assign tag          = alu_result_in[31:IDX_W+4];
    assign hit          = line_valid[idx] && (line_tag[idx] == tag);
    assign last         = (cnt == CNT_W'(MEM_LATENCY - 1));
    assign mem_we       = (state == WRITE) && last && !reset;
    assign rd_out       = rd_in;
    assign unused_write = is_write_in;

    memory_stage_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (MEM_AW)
    ) data_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (alu_result_in[MEM_AW+1:2]),
        .wdata (write_data_in),
        .rline (alu_result_in[MEM_AW+1:4]),
        .rdata (mem_line)
    );

    // Control FSM and cache array; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            line_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (is_store_in) begin
                        state <= WRITE;
                    end else if (is_load_in && !hit) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (last) begin
                        line_valid[idx] <= 1'b1;
                        line_tag[idx]   <= tag;
                        for (int k = 0; k < 4; k++) begin
                            line_data[idx][2'(k)] <= mem_line[32*k +: 32];
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (last) begin
                        if (hit) begin
                            line_data[idx][off] <= write_data_in;
                        end
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall and writeback are combinational so a hit completes in its own cycle.
    always_comb begin
        stall_req   = 1'b0;
        wb_data_out = alu_result_in;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (is_store_in) begin
                        stall_req = 1'b1;
                    end else if (is_load_in) begin
                        if (hit) begin
                            wb_data_out = line_data[idx][off];
                        end else begin
                            stall_req = 1'b1;
                        end
                    end
                end
                FILL, WRITE: begin
                    stall_req = 1'b1;
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

`ifdef MEMORY_STAGE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        unused_perf;

    assign unused_perf = ^{hit_count, miss_count};

    // Saturating load hit/miss counters, sampled where the IDLE decision is made.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && is_load_in && !is_store_in) begin
            if (hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus randomized bench for memory_stage against a line-level cache/memory model.
// Expects the default configuration; MEMORY_STAGE_PERF_CNT_EN additionally checks the counters.

module tb_memory_stage;

    localparam int unsigned MEM_LATENCY = 4;
    localparam int unsigned NUM_LINES   = 4;
    localparam int unsigned MEM_WORDS   = 16384;

    logic        clk;
    logic        reset;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        is_load;
    logic        is_store;
    logic        is_write;
    logic [31:0] wb;
    logic        stall;
    logic [4:0]  rd_o;

    int vectors;
    int miscompares;

    // Reference model: memory words plus, per cache slot, the full line number it holds.
    bit [31:0] mem_m  [MEM_WORDS];
    bit        cv     [NUM_LINES];
    bit [31:0] cline  [NUM_LINES];
    bit [31:0] cdat   [NUM_LINES][4];

    memory_stage #(
        .MEM_LATENCY (MEM_LATENCY),
        .NUM_LINES   (NUM_LINES),
        .MEM_WORDS   (MEM_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_result_in (alu),
        .write_data_in (wdata),
        .rd_in         (rd),
        .is_load_in    (is_load),
        .is_store_in   (is_store),
        .is_write_in   (is_write),
        .wb_data_out   (wb),
        .stall_req     (stall),
        .rd_out        (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned slot_of(input bit [31:0] addr);
        return (addr / 16) % NUM_LINES;
    endfunction

    function automatic int unsigned word_of(input bit [31:0] addr);
        return (addr / 4) % MEM_WORDS;
    endfunction

    function automatic bit model_hit(input bit [31:0] addr);
        return cv[slot_of(addr)] && (cline[slot_of(addr)] == addr / 16);
    endfunction

    function automatic void model_fill(input bit [31:0] addr);
        int unsigned s = slot_of(addr);
        int unsigned base = (addr / 16) * 4;
        cv[s]    = 1'b1;
        cline[s] = addr / 16;
        for (int k = 0; k < 4; k++) cdat[s][k] = mem_m[(base + k) % MEM_WORDS];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_LINES; i++) cv[i] = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic wait_release(output int cyc);
        cyc = 0;
        while (stall === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        is_load  = ld;
        is_store = st;
        alu      = a;
        wdata    = d;
        rd       = 5'($urandom);
        is_write = 1'($urandom);
    endtask

    task automatic do_idle();
        drive(1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_wb", wb, alu);
    endtask

    task automatic do_load(input logic [31:0] addr);
        int cyc;
        bit h;
        h = model_hit(addr);
        drive(1'b1, 1'b0, addr, $urandom);
        @(negedge clk);
        chk("ld_stall0", 32'(stall), h ? 32'd0 : 32'd1);
        chk("ld_rd", 32'(rd_o), 32'(rd));
        if (!h) begin
            @(negedge clk);
            chk("ld_fill_wb", wb, addr);
            chk("ld_fill_stall", 32'(stall), 32'd1);
        end
        wait_release(cyc);
        if (!h) cyc++;
        chk("ld_latency", 32'(cyc), h ? 32'd0 : 32'(MEM_LATENCY + 1));
        if (!h) model_fill(addr);
        chk("ld_data", wb, cdat[slot_of(addr)][(addr / 4) % 4]);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic with_load);
        int cyc;
        drive(with_load, 1'b1, addr, data);
        @(negedge clk);
        chk("st_stall0", 32'(stall), 32'd1);
        wait_release(cyc);
        chk("st_latency", 32'(cyc), 32'(MEM_LATENCY + 1));
        chk("st_done_wb", wb, addr);
        mem_m[word_of(addr)] = data;
        if (model_hit(addr)) cdat[slot_of(addr)][(addr / 4) % 4] = data;
        chk("st_mem", dut.data_mem.data_mem[word_of(addr)], mem_m[word_of(addr)]);
    endtask

    task automatic do_reset(input int n);
        drive(1'b1, 1'b0, $urandom, $urandom);
        reset = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_wb", wb, alu);
            @(posedge clk);
        end
        #1;
        reset   = 1'b0;
        is_load = 1'b0;
        model_clear();
    endtask

    initial begin
        int cyc;
        bit [31:0] a;
        int unsigned op;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1; is_load = 1'b0; is_store = 1'b0; is_write = 1'b0;
        alu = '0; wdata = '0; rd = '0;
        model_clear();

        do_reset(2);
        do_idle();

        // Preload through write-through stores; all miss with an empty cache.
        for (int k = 0; k < 4; k++) do_store(32'h1000 + 32'(4 * k), 32'hAAAA0000 + 32'(k * 32'h1111), 1'b0);
        do_store(32'h2000, 32'hBBBB0000, 1'b0);
        for (int k = 1; k < 4; k++) do_store(32'h2000 + 32'(4 * k), $urandom, 1'b0);
        do_store(32'h3000, 32'hCCCC0000, 1'b0);
        for (int k = 1; k < 4; k++) do_store(32'h3000 + 32'(4 * k), $urandom, 1'b0);
        for (int k = 0; k < 64; k++) do_store(32'(4 * k), $urandom, 1'b0);

        do_reset(2);
        chk("mem_survives_rst", dut.data_mem.data_mem[1024], 32'hAAAA0000);

        do_load(32'h1000);
        chk("req31_w0", wb, 32'hAAAA0000);
        do_load(32'h1004);
        chk("req31_w1", wb, 32'hAAAA1111);
        do_load(32'h1008);
        chk("req31_w2", wb, 32'hAAAA2222);
        do_idle();
`ifdef MEMORY_STAGE_PERF_CNT_EN
        chk("perf_miss", dut.miss_count, 32'd1);
        chk("perf_hit_min3", 32'(dut.hit_count >= 32'd3), 32'd1);
`endif

        do_load(32'h2000);
        chk("req32_b", wb, 32'hBBBB0000);
        do_load(32'h1000);
        chk("req32_evict", wb, 32'hAAAA0000);

        do_store(32'h1000, 32'hDEADBEEF, 1'b0);
        do_idle();
        do_load(32'h1000);
        chk("req33_data", wb, 32'hDEADBEEF);
        chk("req33_mem", dut.data_mem.data_mem[1024], 32'hDEADBEEF);

        do_store(32'h3000, 32'hFACEFEED, 1'b0);
        do_load(32'h3000);
        chk("req34_data", wb, 32'hFACEFEED);

        // Store wins when both requests are raised together.
        do_store(32'h3004, 32'h5A5A1234, 1'b1);
        do_load(32'h3004);

        // Reset in the middle of a line fill.
        do_reset(1);
        drive(1'b1, 1'b0, 32'h1000, 32'h0);
        @(negedge clk);
        chk("rf_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rf_rst_stall", 32'(stall), 32'd0);
        chk("rf_rst_wb", wb, 32'h1000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rf_miss_again", 32'(stall), 32'd1);
        wait_release(cyc);
        chk("rf_latency", 32'(cyc), 32'(MEM_LATENCY + 1));
        model_fill(32'h1000);
        chk("rf_data", wb, cdat[slot_of(32'h1000)][0]);
        chk("rf_mem", dut.data_mem.data_mem[1024], mem_m[1024]);

        // Reset in the middle of a memory write must leave memory untouched.
        drive(1'b0, 1'b1, 32'h1000, 32'h12345678);
        @(negedge clk);
        chk("rw_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (MEM_LATENCY + 2) @(posedge clk);
        #1;
        reset    = 1'b0;
        is_store = 1'b0;
        model_clear();
        do_idle();
        chk("rw_mem", dut.data_mem.data_mem[1024], mem_m[1024]);
        do_load(32'h1000);

        // Randomized mix over a small region; the 64 KiB alias wraps onto the same words.
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'h0001_0000;
            op = $urandom_range(0, 9);
            if (op <= 4)      do_load(a);
            else if (op <= 7) do_store(a, $urandom, 1'b0);
            else if (op == 8) do_idle();
            else              do_store(a, $urandom, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
